// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU result stage, its producer and its consumer.
// The slave modport is the stage's view; the master modport drives it.
interface alu_result_stage_if #(
   parameter int unsigned N = 8
);
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] result;
   logic         carry;
   logic         overflow;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out;
   logic [3:0]   flags;

   modport slave (
      input  in_valid,
      output in_ready,
      input  result,
      input  carry,
      input  overflow,
      output out_valid,
      input  out_ready,
      output out,
      output flags
   );

   modport master (
      output in_valid,
      input  in_ready,
      output result,
      output carry,
      output overflow,
      input  out_valid,
      output out_ready,
      input  out,
      input  flags
   );
endinterface

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: derives N/Z/C/V flags at capture and buffers up
// to two {result, flags} entries in a skid FIFO, plus a sticky overflow flag.
module alu_result_stage #(
   parameter int unsigned N = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   alu_result_stage_if.slave     bus,
   input  logic                  clr_sticky_i,
   output logic                  sticky_v_o
);

   localparam int unsigned EntryW = N + 4;

   logic [EntryW-1:0] mem_q [2];
   logic [1:0]        count_q, count_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              sticky_q, sticky_d;
   logic              push, pop;
   logic [3:0]        new_flags;

   // Handshake outputs depend only on the registered count.
   assign bus.in_ready  = (count_q != 2'd2);
   assign bus.out_valid = (count_q != 2'd0);

   assign push = bus.in_valid & bus.in_ready;
   assign pop  = bus.out_valid & bus.out_ready;

   assign new_flags = {bus.result[N-1], (bus.result == '0), bus.carry, bus.overflow};

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      sticky_d = sticky_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
      if (clr_sticky_i) begin
         sticky_d = 1'b0;
      end
      // Setting on an overflowing push takes priority over a clear.
      if (push && bus.overflow) begin
         sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         sticky_q <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         sticky_q <= sticky_d;
         if (push) begin
            mem_q[wr_ptr_q] <= {bus.result, new_flags};
         end
      end
   end

   assign bus.out    = mem_q[rd_ptr_q][EntryW-1:4];
   assign bus.flags  = mem_q[rd_ptr_q][3:0];
   assign sticky_v_o = sticky_q;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage for the ALU datapath, placed directly downstream of the shift and arithmetic units. It captures the combinational unit result together with its CARRY and OVERFLOW outputs, derives the N/Z/C/V status flags, and buffers up to two results in a skid FIFO behind a valid/ready handshake. This decouples the combinational ALU from the consumer (register file or writeback). It also keeps a sticky overflow flag for software polling.

## Interface
- N, 8, datapath width in bits (N >= 2)
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous reset, active-low
- IN_VALID  in  1  upstream result is valid this cycle
- IN_READY  out  1  stage can accept a result this cycle
- RESULT  in  N  result word from the ALU unit (e.g. the shifter output)
- CARRY  in  1  carry/borrow from the unit; 0 for units without one
- OVERFLOW  in  1  overflow from the unit
- OUT_VALID  out  1  head entry is valid
- OUT_READY  in  1  downstream accepts the head entry
- OUT  out  N  head entry result
- FLAGS  out  4  head entry flags {N,Z,C,V}, bit 3 = N
- STICKY_V  out  1  set by any accepted result with OVERFLOW = 1
- CLR_STICKY  in  1  clears STICKY_V

## Operation
- Push occurs when IN_VALID & IN_READY; pop occurs when OUT_VALID & OUT_READY.
- Flag computation at push time:
  - N = RESULT[N-1]
  - Z = (RESULT == 0)
  - C = CARRY
  - V = OVERFLOW
- Storage is a 2-entry FIFO of {RESULT, FLAGS}, with read pointer, write pointer and a 2-bit count (0..2).
- Entries are delivered strictly in push order. Pointers are 1 bit each and wrap from 1 to 0.
- State is derived from the count:
  - EMPTY (0): OUT_VALID = 0, IN_READY = 1
  - ONE (1): OUT_VALID = 1, IN_READY = 1
  - FULL (2): OUT_VALID = 1, IN_READY = 0
- Count transitions:
  - push only: count + 1
  - pop only: count − 1
  - push and pop together (possible only in ONE): count stays 1; the head advances to the new entry.
- In FULL, IN_VALID is ignored: no push and no overwrite. In EMPTY, OUT_READY is ignored.
- IN_READY and OUT_VALID are registered: they depend only on the count, with no combinational path from IN_VALID or OUT_READY.
- OUT and FLAGS come directly from the head storage entry. When OUT_VALID = 0 they hold their last value, and their content is don't-care.
- STICKY_V:
  - Set on a push with OVERFLOW = 1.
  - Cleared when CLR_STICKY = 1.
  - If both happen in the same cycle, set wins.
  - Not affected by pops.
- Upstream rule: while IN_VALID = 1 and IN_READY = 0, RESULT, CARRY and OVERFLOW must be held stable. This stage does not check the rule.

## Timing
- Reset (RST_N = 0 at a rising edge):
  - count = 0 and both pointers = 0
  - OUT_VALID = 0, IN_READY = 1, STICKY_V = 0
  - OUT = 0, FLAGS = 0
- Reset asserted mid-operation discards all buffered entries at that edge. The stage is EMPTY on the first cycle after RST_N returns to 1.
- Latency: a result pushed at edge k appears with OUT_VALID = 1 in the cycle after edge k, i.e. one cycle.
- Throughput: one result per cycle while OUT_READY = 1 continuously.
- IN_READY and STICKY_V are registered outputs.
- Backpressure: with OUT_READY = 0, two pushes fill the FIFO. IN_READY drops in the cycle after the second push.
- Recovery: a pop from FULL raises IN_READY in the following cycle.

## Test plan
- Reset then single result:
  - Stimulus: RST_N = 0 for 2 cycles, then push RESULT = 8'b00000101, CARRY = 1, OVERFLOW = 0.
  - Response: next cycle OUT_VALID = 1, OUT = 8'h05, FLAGS = 4'b0010. Pop with OUT_READY = 1, then OUT_VALID = 0.
- Zero and negative flags:
  - Stimulus: push 8'h00, then 8'b11110001, with OUT_READY = 1.
  - Response: FLAGS = 4'b0100, then 4'b1000, on consecutive cycles.
- Backpressure:
  - Stimulus: OUT_READY = 0; push 8'h0B, 8'h2B, then hold 8'h45 valid.
  - Response: IN_READY = 0 after the second push and 8'h45 is not accepted. With OUT_READY = 1, outputs are 8'h0B, 8'h2B, 8'h45 in order, and no entry is lost or duplicated.
- Simultaneous push and pop in ONE:
  - Stimulus: hold count at 1 with IN_VALID = 1 and OUT_READY = 1 for 4 cycles.
  - Response: count stays 1 and OUT follows pushed values with 1-cycle lag.
- Sticky overflow:
  - Stimulus: push with OVERFLOW = 1 while CLR_STICKY = 1 in the same cycle.
  - Response: STICKY_V = 1. A later CLR_STICKY = 1 alone gives STICKY_V = 0.
- Reset while full:
  - Stimulus: fill to 2 entries, then RST_N = 0 for 1 cycle.
  - Response: OUT_VALID = 0, IN_READY = 1, STICKY_V = 0, OUT = 0; the old data never reappears.
